// File: rtl/samp_pkg.sv
// Shared I/Q sample types for the sample FIFO and its read-side drain.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: SAMP_W sample component width, Samp {I, Q} packed sample,
// skid occupancy encodings.
package samp_pkg;

  localparam int SAMP_W = 24;

  // I occupies the upper half so the packed value reads as {I[23:0], Q[23:0]}.
  typedef struct packed {
    logic signed [SAMP_W-1:0] i;
    logic signed [SAMP_W-1:0] q;
  } Samp;

  // Skid occupancy: number of samples held locally.
  localparam logic [1:0] CNT_EMPTY = 2'd0;
  localparam logic [1:0] CNT_ONE   = 2'd1;
  localparam logic [1:0] CNT_FULL  = 2'd2;

endpackage

// File: rtl/samp_skid.sv
// Two-entry register slice: head (H) feeds the output, second (S) absorbs one extra sample.
// Latency: a sample written on pop is visible at head the cycle after the pop edge.
// Backpressure: caller must not pop at FULL; xfer only drains, flush empties at the next edge.
// Ports: Clk, Reset (async active-high), pop/xfer/flush strobes, din (sample in),
//        cnt (occupancy), head (oldest sample).
module samp_skid
  import samp_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       pop,
  input  logic       xfer,
  input  logic       flush,
  input  Samp        din,
  output logic [1:0] cnt,
  output Samp        head
);

  logic [1:0] cnt_q, cnt_d;
  Samp        h_q, h_d;
  Samp        s_q, s_d;

  always_comb begin
    cnt_d = cnt_q;
    h_d   = h_q;
    s_d   = s_q;
    case (cnt_q)
      CNT_EMPTY: begin
        if (pop) begin
          h_d   = din;
          cnt_d = CNT_ONE;
        end
      end
      CNT_ONE: begin
        if (pop && xfer) begin
          // Head leaves and is replaced in the same edge: stays at ONE.
          h_d = din;
        end else if (pop) begin
          s_d   = din;
          cnt_d = CNT_FULL;
        end else if (xfer) begin
          cnt_d = CNT_EMPTY;
        end
      end
      CNT_FULL: begin
        if (xfer) begin
          h_d   = s_q;
          cnt_d = CNT_ONE;
        end
      end
      default: cnt_d = CNT_EMPTY;
    endcase
    // Flush discards whatever is held; data registers are left as-is.
    if (flush) begin
      cnt_d = CNT_EMPTY;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q <= CNT_EMPTY;
      h_q   <= '0;
      s_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      h_q   <= h_d;
      s_q   <= s_d;
    end
  end

  assign cnt  = cnt_q;
  assign head = h_q;

endmodule

// File: rtl/samp_fifo_reader.sv
// Read-side drain of the I/Q sample FIFO into a 2-entry skid, presented on PushOut/StopOut.
// Latency: sample popped at edge N is on SampIOut/SampQOut with PushOut=1 the cycle after N.
// Backpressure: StopOut only stalls the skid; FIFO pops stop once both entries are full.
// Ports: Clk, Reset (async active-high); fifo_samp/fifo_empty/fifo_PullOut to the FIFO;
//        FlushIn; PushOut/StopOut/SampIOut/SampQOut downstream;
//        SampCount/StallCount only when SAMP_READER_STATS_EN is defined.
module samp_fifo_reader
  import samp_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned STALL_W = 16
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  Samp                      fifo_samp,
  input  logic                     fifo_empty,
  output logic                     fifo_PullOut,
  input  logic                     FlushIn,
  output logic                     PushOut,
  input  logic                     StopOut,
  output logic signed [SAMP_W-1:0] SampIOut,
  output logic signed [SAMP_W-1:0] SampQOut
`ifdef SAMP_READER_STATS_EN
  ,
  output logic [CNT_W-1:0]         SampCount,
  output logic [STALL_W-1:0]       StallCount
`endif
);

  if (CNT_W == 0 || STALL_W == 0) begin : g_bad_width
    $error("samp_fifo_reader: counter widths must be non-zero");
  end

  logic [1:0] cnt;
  Samp        head;
  logic       pop;
  logic       xfer;

  // Pop depends only on local occupancy, never on StopOut. Reset is folded
  // in so the strobe is low while reset is held even with the FIFO non-empty.
  assign pop          = ~Reset & ~fifo_empty & (cnt != CNT_FULL) & ~FlushIn;
  assign fifo_PullOut = pop;
  assign PushOut      = (cnt != CNT_EMPTY);
  assign xfer         = PushOut & ~StopOut;
  assign SampIOut     = head.i;
  assign SampQOut     = head.q;

  samp_skid u_skid (
    .Clk   (Clk),
    .Reset (Reset),
    .pop   (pop),
    .xfer  (xfer),
    .flush (FlushIn),
    .din   (fifo_samp),
    .cnt   (cnt),
    .head  (head)
  );

`ifdef SAMP_READER_STATS_EN
  logic [CNT_W-1:0]   samp_cnt_q, samp_cnt_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    samp_cnt_d  = samp_cnt_q;
    stall_cnt_d = stall_cnt_q;
    // Delivered count wraps; an xfer in a flush cycle still counts.
    if (xfer) begin
      samp_cnt_d = samp_cnt_q + CNT_W'(1);
    end
    // Stall count saturates rather than wrapping.
    if (PushOut && StopOut && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_W'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      samp_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      samp_cnt_q  <= samp_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign SampCount  = samp_cnt_q;
  assign StallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_samp_fifo_reader.sv
// Bench for samp_fifo_reader: directed stimulus with a FIFO model, scoreboard of delivered samples.
// Latency: n/a.
// Backpressure: StopOut patterns driven per test.
module tb_samp_fifo_reader;
  import samp_pkg::*;

  logic                     Clk = 1'b0;
  logic                     Reset;
  Samp                      fifo_samp;
  logic                     fifo_empty;
  logic                     fifo_PullOut;
  logic                     FlushIn;
  logic                     PushOut;
  logic                     StopOut;
  logic signed [SAMP_W-1:0] SampIOut;
  logic signed [SAMP_W-1:0] SampQOut;
`ifdef SAMP_READER_STATS_EN
  logic [31:0]              SampCount;
  logic [15:0]              StallCount;
`endif

  always #5 Clk = ~Clk;

  samp_fifo_reader dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .fifo_samp    (fifo_samp),
    .fifo_empty   (fifo_empty),
    .fifo_PullOut (fifo_PullOut),
    .FlushIn      (FlushIn),
    .PushOut      (PushOut),
    .StopOut      (StopOut),
    .SampIOut     (SampIOut),
    .SampQOut     (SampQOut)
`ifdef SAMP_READER_STATS_EN
    ,
    .SampCount    (SampCount),
    .StallCount   (StallCount)
`endif
  );

  Samp  src[$];    // FIFO model contents
  Samp  exp_q[$];  // samples expected downstream, in order
  Samp  mon_w;
  logic gap = 1'b0;
  int   checks = 0;
  int   passed = 0;
  int   viol = 0;
  logic [15:0] pm, qm;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act === want) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, want);
  endtask

  function automatic Samp mk(input int k_i, input int k_q);
    Samp s;
    s.i = 24'(k_i);
    s.q = 24'(k_q);
    return s;
  endfunction

  task automatic drive_fifo();
    fifo_empty = gap || (src.size() == 0);
    if (src.size() != 0) fifo_samp = src[0];
    else fifo_samp = '0;
  endtask

  task automatic load(input Samp s, input bit expect_it);
    src.push_back(s);
    if (expect_it) exp_q.push_back(s);
    drive_fifo();
  endtask

  // One call = n cycles; per-cycle input bits, records pop and PushOut per cycle.
  task automatic run(input int n, input logic [15:0] stop_v, input logic [15:0] flush_v,
                     input logic [15:0] gap_v, output logic [15:0] pmask, output logic [15:0] qmask);
    pmask = '0;
    qmask = '0;
    for (int c = 0; c < n; c++) begin
      StopOut = stop_v[c];
      FlushIn = flush_v[c];
      gap     = gap_v[c];
      drive_fifo();
      @(negedge Clk);
      pmask[c] = fifo_PullOut;
      qmask[c] = PushOut;
      if (fifo_PullOut && fifo_empty) viol++;
      @(posedge Clk);
      #1;
      if (pmask[c] && src.size() != 0) void'(src.pop_front());
    end
    gap = 1'b0;
    drive_fifo();
  endtask

  // Scoreboard monitor: every transfer is compared against the head of exp_q.
  always @(negedge Clk) begin
    if (!Reset && PushOut && !StopOut) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL deliver: unexpected sample %0h, none expected", {SampIOut, SampQOut});
      end else begin
        mon_w = exp_q.pop_front();
        check("deliver", {16'h0, SampIOut, SampQOut}, {16'h0, mon_w});
      end
    end
  end

  initial begin
    Reset   = 1'b1;
    StopOut = 1'b0;
    FlushIn = 1'b0;
    for (int k = 1; k <= 8; k++) load(mk(k, -k), 1'b1);
    repeat (2) @(posedge Clk);
    #1;
    check("reset_push", PushOut, 0);
    check("reset_pull", fifo_PullOut, 0);
    check("reset_i", SampIOut, 0);
    check("reset_q", SampQOut, 0);
    Reset = 1'b0;

    // Free-running stream of 8 samples.
    run(11, 16'h0000, 16'h0000, 16'h0000, pm, qm);
    check("stream_pop", pm, 16'h00FF);
    check("stream_push", qm, 16'h01FE);
`ifdef SAMP_READER_STATS_EN
    check("stream_sampcount", SampCount, 8);
`endif

    // Stall for 6 cycles during an 8-sample stream.
    for (int k = 1; k <= 8; k++) load(mk(k, -k), 1'b1);
    run(16, 16'h003F, 16'h0000, 16'h0000, pm, qm);
    check("stall_pop", pm, 16'h1F83);
    check("stall_push", qm, 16'h3FFE);
`ifdef SAMP_READER_STATS_EN
    check("stall_stallcount", StallCount, 5);
    check("stall_sampcount", SampCount, 16);
`endif

    // FIFO empty every other cycle.
    for (int k = 1; k <= 4; k++) load(mk(32'h100 + k, -(32'h100 + k)), 1'b1);
    run(10, 16'h0000, 16'h0000, 16'h02AA, pm, qm);
    check("gap_pop", pm, 16'h0055);
    check("gap_push", qm, 16'h00AA);

    // Flush at FULL (drops first two), then flush while pop-eligible with an xfer.
    for (int k = 1; k <= 4; k++) load(mk(32'h200 + k, -(32'h200 + k)), k >= 3);
    run(8, 16'h0007, 16'h0014, 16'h0000, pm, qm);
    check("flush_pop", pm, 16'h002B);
    check("flush_push", qm, 16'h0056);
    check("flush_drain", exp_q.size(), 0);
`ifdef SAMP_READER_STATS_EN
    check("flush_sampcount", SampCount, 22);
`endif

    // Reset mid-stall with both entries full.
    for (int k = 1; k <= 3; k++) load(mk(32'h300 + k, -(32'h300 + k)), 1'b0);
    run(2, 16'h0003, 16'h0000, 16'h0000, pm, qm);
    check("prereset_push", PushOut, 1);
    check("prereset_i", SampIOut, 24'h000301);
    #2;
    Reset = 1'b1;
    #1;
    check("arst_push", PushOut, 0);
    check("arst_pull", fifo_PullOut, 0);
    check("arst_i", SampIOut, 0);
    check("arst_q", SampQOut, 0);
`ifdef SAMP_READER_STATS_EN
    check("arst_sampcount", SampCount, 0);
    check("arst_stallcount", StallCount, 0);
`endif
    StopOut = 1'b0;
    @(posedge Clk);
    #1;
    src.delete();
    drive_fifo();
    Reset = 1'b0;
    for (int k = 1; k <= 2; k++) load(mk(32'h400 + k, -(32'h400 + k)), 1'b1);
    run(4, 16'h0000, 16'h0000, 16'h0000, pm, qm);
    check("postreset_pop", pm, 16'h0003);
    check("postreset_push", qm, 16'h0006);

`ifdef SAMP_READER_STATS_EN
    // Long stall: StallCount saturates.
    load(mk(32'h500, -32'h500), 1'b1);
    run(1, 16'h0001, 16'h0000, 16'h0000, pm, qm);
    repeat (100) @(posedge Clk);
    #1;
    check("stallcount_100", StallCount, 100);
    repeat (65535) @(posedge Clk);
    #1;
    check("stallcount_sat", StallCount, 16'hFFFF);
    run(3, 16'h0000, 16'h0000, 16'h0000, pm, qm);
    check("final_sampcount", SampCount, 3);
`endif

    check("drain_all", exp_q.size(), 0);
    check("no_pop_when_empty", viol, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
